// File: rtl/la_cmd_bridge_pkg.sv
// Shared definitions for the LA command bridge: op encoding, FSM state codes,
// LA bit positions and the default PING version word.
package la_cmd_bridge_pkg;

    typedef enum logic [1:0] {
        OpRead  = 2'b00,
        OpWrite = 2'b01,
        OpHold  = 2'b10,
        OpPing  = 2'b11
    } la_op_e;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StWaitRsp = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [31:0] VersionDefault = 32'h0001_0000;

    // Host -> bridge fields on la_data_in
    function automatic int unsigned op_pos(input int unsigned data_w, input int unsigned addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int unsigned rq_pos(input int unsigned data_w, input int unsigned addr_w);
        return data_w + addr_w + 2;
    endfunction

    // Bridge -> host fields on la_data_out
    function automatic int unsigned ack_pos(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned err_pos(input int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned hold_pos(input int unsigned data_w);
        return data_w + 2;
    endfunction

    function automatic int unsigned cnt_pos(input int unsigned data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/la_cmd_bridge_fsm.sv
// Command sequencer: latches a pending command, runs the memory handshake and
// signals response/timeout/done to the top. Optional watchdog is enabled by
// defining LA_CMD_BRIDGE_TIMEOUT_EN.
module la_cmd_bridge_fsm
    import la_cmd_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pending_i,
    input  la_op_e            cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output la_op_e            op_o,
    output logic              done_o,
    output logic              rsp_valid_o,
    output logic              timeout_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i
);

    logic [1:0]        state_q, state_d;
    la_op_e            op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              tmo_hit;

`ifdef LA_CMD_BRIDGE_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmrW-1:0] TmoLast = TmrW'(TIMEOUT_CYC - 1);

    logic [TmrW-1:0] timer_q;

    // Watchdog counts cycles spent in ISSUE+WAIT_RSP, zero whenever idle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (state_q == StIssue || state_q == StWaitRsp) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    assign tmo_hit = (timer_q == TmoLast);
`else
    logic [31:0] tmo_unused;
    assign tmo_unused = 32'(TIMEOUT_CYC);
    assign tmo_hit    = 1'b0;
`endif

    // Next-state logic; a real response always wins over the watchdog
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_o = 1'b0;
        timeout_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_i) begin
                    op_d    = cmd_op_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    state_d = (cmd_op_i == OpRead || cmd_op_i == OpWrite) ? StIssue : StDone;
                end
            end
            StIssue: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    rsp_valid_o = 1'b1;
                    state_d     = StDone;
                end else if (mem_gnt_i) begin
                    state_d = StWaitRsp;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                    state_d   = StDone;
                end
            end
            StWaitRsp: begin
                if (mem_rvalid_i) begin
                    rsp_valid_o = 1'b1;
                    state_d     = StDone;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched command registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpRead;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign op_o        = op_q;
    assign done_o      = (state_q == StDone);
    assign mem_req_o   = (state_q == StIssue);
    assign mem_we_o    = (op_q == OpWrite);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/la_cmd_bridge.sv
// LA command bridge top: unpacks the toggle-handshaked command from the LA
// lines, owns the host-visible status registers and packs la_data_out.
// Optional bus watchdog: define LA_CMD_BRIDGE_TIMEOUT_EN.
// DATA_W+ADDR_W+3 must not exceed 128.
module la_cmd_bridge
    import la_cmd_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter bit          HOLD_RST    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter logic [31:0] VERSION     = VersionDefault
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [127:0]      la_data_in,
    input  logic [127:0]      la_oenb,
    output logic [127:0]      la_data_out,
    output logic              core_hold_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    localparam int unsigned OpPos   = op_pos(DATA_W, ADDR_W);
    localparam int unsigned RqPos   = rq_pos(DATA_W, ADDR_W);
    localparam int unsigned AckPos  = ack_pos(DATA_W);
    localparam int unsigned ErrPos  = err_pos(DATA_W);
    localparam int unsigned HoldPos = hold_pos(DATA_W);
    localparam int unsigned CntPos  = cnt_pos(DATA_W);

    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] version_w;

    logic   pending;
    la_op_e cur_op;
    logic   done, rsp_valid, timeout;
    logic   la_unused;

    // Only the command field bits matter; the rest is deliberately ignored
    assign la_unused = ^{la_data_in, la_oenb};

    if (DATA_W <= 32) begin : g_ver_trunc
        assign version_w = VERSION[DATA_W-1:0];
    end else begin : g_ver_ext
        assign version_w = {{(DATA_W - 32){1'b0}}, VERSION};
    end

    // Level compare so a toggle is never lost, gated by the host output enable
    assign pending = (la_data_in[RqPos] != ack_q) && !la_oenb[RqPos];

    la_cmd_bridge_fsm #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk_i        (wb_clk_i),
        .rst_ni       (wb_rst_ni),
        .pending_i    (pending),
        .cmd_op_i     (la_op_e'(la_data_in[OpPos +: 2])),
        .cmd_addr_i   (la_data_in[DATA_W +: ADDR_W]),
        .cmd_wdata_i  (la_data_in[DATA_W-1:0]),
        .op_o         (cur_op),
        .done_o       (done),
        .rsp_valid_o  (rsp_valid),
        .timeout_o    (timeout),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i)
    );

    // Status next-state: capture bus response, apply timeout, retire in DONE
    always_comb begin
        ack_d   = ack_q;
        err_d   = err_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        if (rsp_valid) begin
            err_d = mem_err_i;
            if (cur_op == OpRead) begin
                rdata_d = mem_rdata_i;
            end
        end
        if (timeout) begin
            err_d   = 1'b1;
            rdata_d = '0;
        end
        if (done) begin
            ack_d = ~ack_q;
            cnt_d = cnt_q + 8'd1;
            case (cur_op)
                OpHold: begin
                    hold_d = mem_wdata_o[0];
                    err_d  = 1'b0;
                end
                OpPing: begin
                    rdata_d = version_w;
                    err_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Host-visible status registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= HOLD_RST;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Pack status onto the LA return lines; unused bits stay 0
    always_comb begin
        la_data_out                  = '0;
        la_data_out[DATA_W-1:0]      = rdata_q;
        la_data_out[AckPos]          = ack_q;
        la_data_out[ErrPos]          = err_q;
        la_data_out[HoldPos]         = hold_q;
        la_data_out[CntPos +: 8]     = cnt_q;
    end

    assign core_hold_o = hold_q;

endmodule

// File: doc/la_cmd_bridge.md
Name: la_cmd_bridge

Overview:
- Parametrised successor to the fixed-width logic-analyzer hookup of the user project.
- Turns management-SoC LA lines into a toggle-handshaked command channel: word read/write into the RISC-V SBC's memory bus, core-hold control, and ping.
- Sits between the wrapper's la_data_in/la_data_out/la_oenb and the core's memory arbiter.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 16, word address width; must satisfy DATA_W+ADDR_W+3 <= 128.
- HOLD_RST, 1, reset value of core_hold_o (core held until firmware is loaded).
- TIMEOUT_CYC, 1023, max cycles in ISSUE+WAIT_RSP before abort (timeout feature only).
- VERSION, 32'h0001_0000, value returned by PING, truncated/zero-extended to DATA_W.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  synchronous, active-low reset.
- la_data_in  in  128  [DATA_W-1:0] wdata; [+ADDR_W] addr; next 2 bits op; next 1 bit req_tog (index RQ = DATA_W+ADDR_W+2).
- la_oenb  in  128  command accepted only while la_oenb[RQ] == 0.
- la_data_out  out  128  [DATA_W-1:0] rdata; bit DATA_W ack_tog; DATA_W+1 err; DATA_W+2 core_hold; [DATA_W+10:DATA_W+3] cmd_count; rest 0.
- core_hold_o  out  1  holds RISC-V core in reset when 1.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word address.
- mem_wdata_o  out  DATA_W  write data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  response valid (reads and writes).
- mem_rdata_i  in  DATA_W  read data.
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i.

Behaviour:
- Reset (wb_rst_ni low at an edge): state IDLE; all outputs and la_data_out 0 except core_hold = HOLD_RST; cmd_count 0; timer 0.
- pending = (req_tog != ack_tog) && !la_oenb[RQ]. Level compare, so no edges are lost. Host must not toggle again until ack_tog == req_tog.
- Ops: 00 READ, 01 WRITE, 10 HOLD (core_hold <= wdata[0]), 11 PING.
- FSM IDLE -> (pending) latch op/addr/wdata. READ/WRITE go to ISSUE; HOLD/PING go to DONE.
- ISSUE: mem_req_o=1, addr/we/wdata stable. If mem_gnt_i, go to WAIT_RSP. If mem_rvalid_i arrives in the same cycle as mem_gnt_i, treat as a response and go to DONE.
- WAIT_RSP: mem_req_o=0; on mem_rvalid_i capture rdata (reads only; writes leave rdata unchanged) and err = mem_err_i, then go to DONE.
- DONE (1 cycle): toggle ack_tog; cmd_count += 1 (8-bit, wraps 255->0); err cleared for HOLD/PING; PING sets rdata = VERSION. Then return to IDLE.
- Latency with gnt in the ISSUE cycle and rvalid one cycle later: ack_tog changes 4 edges after req_tog toggles. HOLD/PING: 2 edges.
- mem_rvalid_i outside WAIT_RSP/ISSUE is ignored.
- core_hold changes only via HOLD or reset.
- Reset mid-transaction aborts immediately: mem_req_o=0 next cycle, no ack; a late response is ignored.
- la_oenb[RQ] rising while busy does not abort the command in flight.

Optional Feature:
- Macro LA_CMD_BRIDGE_TIMEOUT_EN.
- Defined: a counter runs during ISSUE/WAIT_RSP and clears on entry. When it reaches TIMEOUT_CYC, drop mem_req_o, set err=1, rdata=0, go to DONE (ack and count still advance). A later stray rvalid is ignored.
- Undefined: no counter; the FSM waits indefinitely; err comes only from mem_err_i.

Decomposition:
- Package la_cmd_bridge_pkg: op encoding enum, FSM state enum, LA bit-offset localparam functions (RQ, ACK, ERR, HOLD, CNT positions), VERSION default.
- One natural sub-module: la_cmd_bridge_fsm (state, timer, mem handshake). Top does LA packing/unpacking and output registers.

Test Plan:
- Reset with HOLD_RST=1 -> la_data_out all 0 except core_hold bit=1; core_hold_o=1; mem_req_o=0.
- READ addr 16'h0040, gnt same cycle, rvalid+rdata 32'hCAFE_F00D next -> rdata=CAFE_F00D, err=0, ack toggled 4 edges after req, cmd_count=1.
- WRITE addr 16'h0010 data 32'h1234_5678 with gnt delayed 3 cycles -> mem_req_o held 4 cycles, stable addr/data, mem_we_o=1; rdata unchanged after response.
- HOLD wdata=0 then PING -> core_hold_o=0; rdata=VERSION; each acks in 2 edges; req toggle with la_oenb[RQ]=1 -> no action.
- READ with rvalid+mem_err_i=1 -> err=1. With LA_CMD_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=15 and no gnt -> abort after 15 cycles, err=1, rdata=0, ack toggled.
- 256 PINGs -> cmd_count wraps to 0. Reset asserted in WAIT_RSP, then rvalid -> ignored, no ack.
